serial_lane_arbiter: RTL

//  Shares one serial shift lane between two parallel-word requesters.
//  - Arbitrates round-robin between the requesters.
//  - Captures the winning WIDTH-bit word into an internal shift register.
//  - Shifts the word out LSB-first, one bit per clk, with framing strobes.
//  - Enforces a programmable idle gap between frames.

---
 rtl/serial_lane_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/serial_lane_arbiter.sv
// Round-robin arbiter that lets two word producers share one serial lane.
// It captures the winning word, shifts it out LSB-first with framing strobes, then inserts an idle gap.
module serial_lane_arbiter #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             so,
  output logic             so_valid,
  output logic             so_first,
  output logic             so_last,
  output logic             so_src,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int CW = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
  localparam int GW = ($clog2(GAP + 1) < 1) ? 1 : $clog2(GAP + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [CW-1:0]    r_cnt;
  logic [GW-1:0]    r_gcnt;
  logic             r_src;
  logic             r_rr;

  logic w_idle;
  logic w_any;
  logic w_grant;

  // Handshake: a word moves when reqN_valid and reqN_ready are both high in the
  // same cycle; ready depends only on state and the valids, never on the data.
  assign w_idle  = (r_state == S_IDLE);
  assign w_any   = req0_valid | req1_valid;
  assign w_grant = (req0_valid && req1_valid) ? r_rr : req1_valid;

  assign req0_ready = !rst && w_idle && w_any && !w_grant;
  assign req1_ready = !rst && w_idle && w_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_gcnt  <= '0;
      r_src   <= 1'b0;
      r_rr    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_SHIFT;
            r_cnt   <= '0;
            r_sreg  <= w_grant ? req1_data : req0_data;
            r_src   <= w_grant;
            r_rr    <= ~w_grant;
          end
        end
        S_SHIFT: begin
          r_sreg <= {1'b0, r_sreg[WIDTH-1:1]};
          if (r_cnt == CNT_LAST) begin
            if (GAP > 0) begin
              r_state <= S_GAP;
              r_gcnt  <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (r_gcnt == GAP_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_gcnt <= r_gcnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Lane outputs decode purely from registered state so they are glitch-free.
  assign so        = (r_state == S_SHIFT) && r_sreg[0];
  assign so_valid  = (r_state == S_SHIFT);
  assign so_first  = (r_state == S_SHIFT) && (r_cnt == '0);
  assign so_last   = (r_state == S_SHIFT) && (r_cnt == CNT_LAST);
  assign so_src    = r_src;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule
